// File: rtl/muldiv_unit.sv
// Purpose : MIPS multiply/divide unit owning HI/LO: MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
// Latency : start sampled at edge 1, HI/LO written and done pulsed at edge WIDTH+2; MTHI/MTLO write at edge 1.
// Backpr. : busy high while an operation is in flight; start (incl. MTHI/MTLO) is dropped, never queued.
//
// Ports: clk/rst_n (async active-low) | start, op, func, a (rs), b (rt) request sampled together |
//        flush aborts the in-flight op | busy, done (1-cycle) | hi, lo registers | rdata = MFHI/MFLO read mux.
// Build option: define MULDIV_MADD_EN to accept SPECIAL2 MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef MULDIV_MADD_EN
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;
    logic [1:0] dec_acc;
    logic [1:0] acc_mode;
`endif

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] p;        // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   d;        // multiplicand or divisor magnitude
    logic               neg_res;
    logic               neg_rem;
    logic               dz;       // divide by zero: quotient keeps its raw all-ones value
    logic               is_div;

    // ---------------- decode ----------------
    logic dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;

    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
`ifdef MULDIV_MADD_EN
        dec_acc  = ACC_NONE;
`endif
        if (op == OP_SPECIAL) begin
            case (func)
                F_MTHI:  dec_mthi = 1'b1;
                F_MTLO:  dec_mtlo = 1'b1;
                F_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
                F_MULTU: dec_mul = 1'b1;
                F_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
                F_DIVU:  dec_div = 1'b1;
                default: ;
            endcase
        end
`ifdef MULDIV_MADD_EN
        else if (op == OP_SPECIAL2) begin
            case (func)
                6'h00:   begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_ADD; end
                6'h01:   begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
                6'h04:   begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_SUB; end
                6'h05:   begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
                default: ;
            endcase
        end
`endif
    end

    // flush in the request cycle drops the request
    logic accept;
    assign accept = start && !flush && (state == S_IDLE);

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = dec_sgn & a[WIDTH-1];
    assign b_neg = dec_sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // ---------------- one iteration ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? d : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, p[WIDTH-1:1]};

    // Compare in WIDTH+1 bits so a zero divisor still sees the full shifted remainder.
    logic [WIDTH:0]     div_sh, div_dif;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_dif  = div_sh - {1'b0, d};
    assign div_ge   = (div_sh >= {1'b0, d});
    assign div_next = {(div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0]), p[WIDTH-2:0], div_ge};

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    assign prod_s = neg_res ? -p : p;
    assign quo_s  = (neg_res && !dz) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign rem_s  = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            p       <= '0;
            d       <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            is_div  <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_mode <= ACC_NONE;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (dec_mul) begin
                            state   <= S_MUL;
                            busy    <= 1'b1;
                            cnt     <= '0;
                            is_div  <= 1'b0;
                            p       <= {{WIDTH{1'b0}}, b_mag};
                            d       <= a_mag;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            dz      <= 1'b0;
`ifdef MULDIV_MADD_EN
                            acc_mode <= dec_acc;
`endif
                        end else if (dec_div) begin
                            state   <= S_DIV;
                            busy    <= 1'b1;
                            cnt     <= '0;
                            is_div  <= 1'b1;
                            p       <= {{WIDTH{1'b0}}, a_mag};
                            d       <= b_mag;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            dz      <= (b == '0);
`ifdef MULDIV_MADD_EN
                            acc_mode <= ACC_NONE;
`endif
                        end else if (dec_mthi) begin
                            hi <= a;
                        end else if (dec_mtlo) begin
                            lo <= a;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        p   <= (state == S_DIV) ? div_next : mul_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_ITER) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_s;
                            lo <= quo_s;
                        end else begin
`ifdef MULDIV_MADD_EN
                            case (acc_mode)
                                ACC_ADD: {hi, lo} <= {hi, lo} + prod_s;
                                ACC_SUB: {hi, lo} <= {hi, lo} - prod_s;
                                default: {hi, lo} <= prod_s;
                            endcase
`else
                            {hi, lo} <= prod_s;
`endif
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = (func == F_MFHI) ? hi :
                   (func == F_MFLO) ? lo : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [5:0]    op = '0;
    logic [5:0]    func = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          flush = 1'b0;
    logic          busy, done;
    logic [W-1:0]  hi, lo, rdata;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .func(func),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural model: kind 0 = ignored, 1 = immediate HI/LO move, 2 = multi-cycle op.
    task automatic model(input logic [5:0] o, input logic [5:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y, output int kind);
        logic signed [63:0] sx, sy, prod, q, r;
        logic [63:0]        acc;
        sx = {{32{x[W-1]}}, x};
        sy = {{32{y[W-1]}}, y};
        kind = 0;
        if (o == 6'h00) begin
            case (f)
                6'h11: begin mhi = x; kind = 1; end
                6'h13: begin mlo = x; kind = 1; end
                6'h18: begin prod = sx * sy; {mhi, mlo} = prod; kind = 2; end
                6'h19: begin prod = {32'b0, x} * {32'b0, y}; {mhi, mlo} = prod; kind = 2; end
                6'h1A, 6'h1B: begin
                    kind = 2;
                    if (y == 0) begin
                        mhi = x; mlo = '1;
                    end else if (f == 6'h1A) begin
                        q = sx / sy; r = sx % sy;
                        mlo = q[W-1:0]; mhi = r[W-1:0];
                    end else begin
                        mlo = x / y; mhi = x % y;
                    end
                end
                default: kind = 0;
            endcase
        end
`ifdef MULDIV_MADD_EN
        else if (o == 6'h1C && (f == 6'h00 || f == 6'h01 || f == 6'h04 || f == 6'h05)) begin
            kind = 2;
            if (f[0]) prod = {32'b0, x} * {32'b0, y};
            else      prod = sx * sy;
            acc = {mhi, mlo};
            if (f[2]) acc = acc - prod;
            else      acc = acc + prod;
            {mhi, mlo} = acc;
        end
`endif
    endtask

    // Called at a negedge; returns at the negedge after completion so the next
    // request lands in the cycle done is high. inj>0 fires an MTHI at that cycle.
    task automatic run_op(input logic [5:0] o, input logic [5:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y, input int inj);
        int kind;
        int n;
        logic [W-1:0] ohi, olo;
        ohi = mhi; olo = mlo;
        model(o, f, x, y, kind);
        op = o; func = f; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (kind != 2) begin
            chk("imm_busy", busy, 0);
            chk("imm_done", done, 0);
            chk("imm_hi", hi, mhi);
            chk("imm_lo", lo, mlo);
        end else begin
            chk("busy_e1", busy, 1);
            n = 1;
            while (!done && n < W + 10) begin
                if (n == inj) begin
                    op = 6'h00; func = 6'h11; a = 32'hDEADBEEF; start = 1'b1;
                end
                if (n > 1 && (hi !== ohi || lo !== olo)) chk("hilo_early", {hi, lo}, {ohi, olo});
                @(negedge clk);
                start = 1'b0;
                n++;
            end
            chk("latency", n, W + 2);
            chk("res_hi", hi, mhi);
            chk("res_lo", lo, mlo);
            chk("busy_end", busy, 0);
            op = 6'h00; func = 6'h10; #1;
            chk("rd_mfhi", rdata, mhi);
            func = 6'h12; #1;
            chk("rd_mflo", rdata, mlo);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : main
        int any_done;
        logic [5:0] fl [10];
        fl = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h18, 6'h1A, 6'h05, 6'h12};

        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors
        run_op(6'h00, 6'h18, 32'hFFFFFFFD, 32'd7, 0);
        chk("mult_neg_lo", lo, 32'hFFFFFFEB);
        run_op(6'h00, 6'h1B, 32'd100, 32'd7, 0);
        chk("divu_q", lo, 32'd14);
        run_op(6'h00, 6'h1A, -32'd100, 32'd7, 0);
        chk("div_r", hi, 32'hFFFFFFFE);
        run_op(6'h00, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("div_ovf_q", lo, 32'h80000000);
        run_op(6'h00, 6'h1B, 32'h1234, 32'h0, 0);
        chk("divu_z_r", hi, 32'h1234);
        run_op(6'h00, 6'h1A, 32'hFFFFFF00, 32'h0, 0);
        run_op(6'h00, 6'h11, 32'hAAAA0000, 32'h0, 0);
        run_op(6'h00, 6'h13, 32'h00005555, 32'h0, 0);
        // MTHI mid-MULT must be ignored
        run_op(6'h00, 6'h19, 32'd1000, 32'd3000, 5);

        // flush mid-MULTU keeps prior hi/lo
        op = 6'h00; func = 6'h19; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        any_done = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) any_done++;
        end
        chk("flush_nodone", any_done, 0);
        chk("flush_hi", hi, mhi);
        chk("flush_lo", lo, mlo);

        // flush and start together in IDLE: start dropped
        op = 6'h00; func = 6'h18; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);

        // accumulate: same stimulus either build, the model decides
        run_op(6'h00, 6'h11, 32'h0, 32'h0, 0);
        run_op(6'h00, 6'h13, 32'd10, 32'h0, 0);
        run_op(6'h1C, 6'h01, 32'd3, 32'd4, 0);
        run_op(6'h1C, 6'h04, 32'd5, 32'd5, 0);
        run_op(6'h1C, 6'h00, 32'hFFFFFFFE, 32'd7, 0);

        // randomized traffic, back to back
        for (int i = 0; i < 40; i++) begin
            logic [5:0] o, f;
            o = 6'h00;
            f = fl[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) begin
                o = 6'h1C;
                f = 6'($urandom_range(0, 5));
            end else if ($urandom_range(0, 9) == 0) begin
                o = 6'h01;
            end
            run_op(o, f, pick_operand(), pick_operand(), 0);
        end

        // async reset mid-DIV clears everything at once
        op = 6'h00; func = 6'h1A; a = 32'd12345; b = 32'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        mhi = '0; mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(6'h00, 6'h18, 32'd7, 32'hFFFFFFF9, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
